// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters through an IDLE/EXEC/DONE sequence.
// Optional macro ALU_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [2:0]            op0,
  input  logic [2:0]            op1,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] b0,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] b1,
  input  logic                  setf0,
  input  logic                  setf1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rsp_valid0,
  output logic                  rsp_valid1,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic [3:0]            nzcv,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_y,
  input  logic                  alu_n,
  input  logic                  alu_z,
  input  logic                  alu_c,
  input  logic                  alu_v,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester holds reqN with stable operands; gntN pulses for the
  // EXEC cycle when the operands have been taken, and rspN_valid pulses one cycle
  // later with rsp_data. A req still high in the following IDLE is a new request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_nxt;
  logic                  owner_q;
  logic                  setf_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  win;
  logic                  grant;

  assign grant = (state_q == IDLE) && (req0 || req1);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_served_q;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    win = ~req0;
    if (req0 && req1) win = ~last_served_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_served_q <= 1'b1;
    else if (grant) last_served_q <= win;
  end
`else
  always_comb win = ~req0;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      setf_q   <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= 3'b000;
      result_q <= '0;
      nzcv     <= 4'b0000;
    end else begin
      state_q <= state_nxt;
      if (grant) begin
        owner_q  <= win;
        setf_q   <= win ? setf1 : setf0;
        alu_a    <= win ? a1 : a0;
        alu_b    <= win ? b1 : b0;
        alu_ctrl <= win ? op1 : op0;
      end
      if (state_q == EXEC) begin
        result_q <= alu_y;
        if (setf_q) nzcv <= {alu_n, alu_z, alu_c, alu_v};
      end
    end
  end

  assign gnt0       = (state_q == EXEC) && !owner_q;
  assign gnt1       = (state_q == EXEC) &&  owner_q;
  assign rsp_valid0 = (state_q == DONE) && !owner_q;
  assign rsp_valid1 = (state_q == DONE) &&  owner_q;
  assign rsp_data   = result_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU/flag model, expected-result queue, directed and random scenarios.
// Honours ALU_ARB_ROUND_ROBIN_EN to pick the expected tie-break order.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, setf0, setf1;
  logic [2:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, rsp_valid0, rsp_valid1, busy;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_y;
  logic [3:0]   nzcv;
  logic [2:0]   alu_ctrl;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_nzcv;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .setf0(setf0), .setf1(setf1),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .busy(busy), .nzcv(nzcv),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .dbg_state(dbg_state)
  );

  // Reference ALU: {N,Z,C,V,result}; C means "no borrow" for subtraction.
  function automatic logic [W+3:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] y;
    logic         c, v;
    s = '0; y = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b};  y = s[W-1:0]; c = s[W]; v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 1; y = s[W-1:0]; c = s[W]; v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]); end
      3'd2: begin s = {1'b0, b} + {1'b0, ~a} + 1; y = s[W-1:0]; c = s[W]; v = (a[W-1] != b[W-1]) && (y[W-1] != b[W-1]); end
      3'd3: y = a & ~b;
      3'd4: y = a & b;
      3'd5: y = a | b;
      3'd6: y = a ^ b;
      default: y = ~(a ^ b);
    endcase
    return {y[W-1], (y == '0), c, v, y};
  endfunction

  assign {alu_n, alu_z, alu_c, alu_v, alu_y} = ref_alu(alu_ctrl, alu_a, alu_b);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_nzcv = 4'b0000;
    exp_q.delete();
  endtask

  // Caller is at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input int port, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic setf, input string tag);
    logic [W+3:0] r;
    logic         g, other;
    int           n;
    r = ref_alu(op, a, b);
    exp_q.push_back(r[W-1:0]);
    if (port == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; setf0 = setf; end
    else           begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; setf1 = setf; end
    n = 0;
    do begin
      @(negedge clk); n++;
      g = (port == 0) ? gnt0 : gnt1;
    end while (!g && n < 8);
    checks++;
    if (n != 1) begin failures++; $display("FAIL %s gnt_latency: got %0d cycles expected 1", tag, n); end
    req0 = 1'b0; req1 = 1'b0;
    if (g) begin
      other = (port == 0) ? gnt1 : gnt0;
      checks++; if (other !== 1'b0) begin failures++; $display("FAIL %s other_gnt: got %b expected 0", tag, other); end
      checks++; if (alu_a !== a) begin failures++; $display("FAIL %s alu_a: got %h expected %h", tag, alu_a, a); end
      checks++; if (alu_b !== b) begin failures++; $display("FAIL %s alu_b: got %h expected %h", tag, alu_b, b); end
      checks++; if (alu_ctrl !== op) begin failures++; $display("FAIL %s alu_ctrl: got %h expected %h", tag, alu_ctrl, op); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_exec: got %b expected 1", tag, busy); end
      @(negedge clk);
      if (setf) exp_nzcv = r[W+3:W];
      checks++;
      if ({rsp_valid1, rsp_valid0} !== ((port == 0) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL %s rsp_valid: got %b expected %b", tag, {rsp_valid1, rsp_valid0}, (port == 0) ? 2'b01 : 2'b10);
      end
      checks++; if (rsp_data !== exp_q[0]) begin failures++; $display("FAIL %s rsp_data: got %h expected %h", tag, rsp_data, exp_q[0]); end
      checks++; if (nzcv !== exp_nzcv) begin failures++; $display("FAIL %s nzcv: got %b expected %b", tag, nzcv, exp_nzcv); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_idle: got %b expected 0", tag, busy); end
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    checks++; if ({gnt0, gnt1, rsp_valid0, rsp_valid1, busy} !== 5'b0) begin failures++; $display("FAIL reset_ctl: got %b expected 00000", {gnt0, gnt1, rsp_valid0, rsp_valid1, busy}); end
    checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (nzcv !== 4'b0) begin failures++; $display("FAIL reset_nzcv: got %b expected 0000", nzcv); end
    checks++; if ({alu_a, alu_b, alu_ctrl} !== '0) begin failures++; $display("FAIL reset_alu: got %h %h %h expected 0", alu_a, alu_b, alu_ctrl); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    apply_reset();
  endtask

  task automatic test_flags();
    do_op(0, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, "overflow");
    checks++; if (nzcv !== 4'b1001) begin failures++; $display("FAIL overflow_nzcv_const: got %b expected 1001", nzcv); end
    do_op(1, 3'b001, 32'd5, 32'd5, 1'b0, "setf0");
    checks++; if (nzcv !== 4'b1001) begin failures++; $display("FAIL setf0_nzcv_const: got %b expected 1001", nzcv); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) b = a;
      do_op($urandom_range(0, 1), 3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  // Both requesters held high from reset: grants every 3 cycles in policy order.
  task automatic test_tie();
    int owner;
    logic [W-1:0] d;
    apply_reset();
    req0 = 1'b1; op0 = 3'b000; a0 = 32'd1; b0 = 32'd2; setf0 = 1'b0;
    req1 = 1'b1; op1 = 3'b110; a1 = 32'd3; b1 = 32'd5; setf1 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
`ifdef ALU_ARB_ROUND_ROBIN_EN
      owner = ((k - 1) / 3) % 2;
`else
      owner = 0;
`endif
      checks++;
      if (gnt0 !== (k % 3 == 1 && owner == 0) || gnt1 !== (k % 3 == 1 && owner == 1)) begin
        failures++; $display("FAIL tie_gnt k=%0d: got %b%b expected owner %0d gnt=%0d", k, gnt1, gnt0, owner, (k % 3 == 1));
      end
      if (k % 3 == 2) begin
        d = (owner == 0) ? 32'd3 : 32'd6;
        checks++; if (rsp_data !== d) begin failures++; $display("FAIL tie_rsp_data k=%0d: got %h expected %h", k, rsp_data, d); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_op(0, 3'b000, 32'h7FFF_FFFF, 32'h1, 1'b1, "pre_reset");
    req0 = 1'b1; op0 = 3'b000; a0 = 32'd1; b0 = 32'd1; setf0 = 1'b1;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL rstmid_gnt: got %b expected 1", gnt0); end
    rst = 1'b1; req0 = 1'b0;
    #1;
    checks++; if ({busy, gnt0, dbg_state} !== 4'b0) begin failures++; $display("FAIL rstmid_exec_state: got %b expected 0000", {busy, gnt0, dbg_state}); end
    checks++; if (nzcv !== 4'b0) begin failures++; $display("FAIL rstmid_exec_nzcv: got %b expected 0000", nzcv); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid0 !== 1'b0) begin failures++; $display("FAIL rstmid_no_rsp: got %b expected 0", rsp_valid0); end
    end
    req0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'd1;
    repeat (2) @(negedge clk);
    checks++; if (nzcv !== 4'b0110) begin failures++; $display("FAIL rstmid_done_pre: got %b expected 0110", nzcv); end
    rst = 1'b1; req0 = 1'b0;
    #1;
    checks++; if ({rsp_valid0, busy, dbg_state, nzcv} !== 8'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", {rsp_valid0, busy, dbg_state, nzcv}); end
    @(negedge clk); rst = 1'b0;
    exp_nzcv = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] r;
    do_op(1, 3'b000, 32'hFFFF_FFFF, 32'h1, 1'b1, "b2b_flags");
    r = ref_alu(3'b011, 32'hFF, 32'h0F);
    req0 = 1'b1; op0 = 3'b011; a0 = 32'hFF; b0 = 32'h0F; setf0 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++; if (gnt0 !== (k % 3 == 1)) begin failures++; $display("FAIL b2b_gnt k=%0d: got %b expected %b", k, gnt0, (k % 3 == 1)); end
      if (k == 7) req0 = 1'b0;
      if (k % 3 == 2) begin
        checks++; if (rsp_data !== r[W-1:0] || rsp_data !== 32'hF0) begin failures++; $display("FAIL b2b_rsp_data k=%0d: got %h expected f0", k, rsp_data); end
        checks++; if (nzcv !== exp_nzcv) begin failures++; $display("FAIL b2b_nzcv k=%0d: got %b expected %b", k, nzcv, exp_nzcv); end
      end
    end
  endtask

  initial begin
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; setf0 = 1'b0; setf1 = 1'b0;
    exp_nzcv = 4'b0000;
    test_reset();
    test_flags();
    test_random();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
